// File: rtl/fod_spi_pkg.sv
// rtl/fod_spi_pkg.sv - shared addresses, CTRL bit positions, FSM state type and FCW reset helper
package fod_spi_pkg;

   localparam int ADDR_CTRL   = 0;
   localparam int ADDR_FCW_HI = 1;
   localparam int ADDR_FCW_LO = 2;

   localparam int SYS_EN_B = 0;
   localparam int COMMIT_B = 1;
   localparam int ERRCLR_B = 15;

   typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

   // 4.25 * 2^wf, i.e. 17 * 2^(wf-2)
   function automatic logic [63:0] fcw_reset_val(input int wf);
      return 64'd17 << (wf - 2);
   endfunction

endpackage

// File: rtl/fod_spi_sync.sv
// rtl/fod_spi_sync.sv - two-flop synchroniser with rise/fall detect on the synchronised level
module fod_spi_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic meta;
   logic q;
   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
         prev <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
         prev <= q;
      end
   end

   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/fod_spi_regfile.sv
// rtl/fod_spi_regfile.sv - oversampled SPI slave register bank with double-buffered FCW
module fod_spi_regfile
   import fod_spi_pkg::*;
#(
   parameter int WI   = 7,
   parameter int WF   = 16,
   parameter int AW   = 6,
   parameter int DW   = 16,
   parameter int NREG = 16
) (
   input  logic                 CLK,
   input  logic                 NARST,
   input  logic                 SCLK,
   input  logic                 CSN,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic                 MISO_OE,
   output logic [NREG*DW-1:0]   REG_Q,
   output logic [WI+WF-1:0]     FCW_FOD,
   output logic                 SYS_EN,
   output logic                 FREQ_HOP,
   output logic                 SPI_ERR
);

   localparam int L  = 1 + AW + DW;
   localparam int CW = $clog2(L + 1);
   localparam logic [2*DW-1:0] FCW_RST = (2*DW)'(fcw_reset_val(WF));
   localparam logic [DW-1:0] CTRL_KEEP = ~((DW'(1) << COMMIT_B) | (DW'(1) << ERRCLR_B));

   logic sclk_rise, sclk_fall, csn_rise, csn_fall;
   logic mosi_m, mosi_s;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [AW:0]   hdr;
   logic [DW-1:0] rx;
   logic [DW-1:0] tx;
   logic [DW-1:0] regs [NREG];
   logic [DW-1:0] sh_hi, sh_lo;

   logic [AW:0]   hdr_nxt;
   logic [DW-1:0] rd_val;
   logic          rw;
   logic [AW-1:0] addr;
   logic          nxt_valid, wr_valid;

   fod_spi_sync #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk(CLK), .rst_n(NARST), .d(SCLK), .rise(sclk_rise), .fall(sclk_fall)
   );

   fod_spi_sync #(.RST_VAL(1'b1)) u_csn_sync (
      .clk(CLK), .rst_n(NARST), .d(CSN), .rise(csn_rise), .fall(csn_fall)
   );

   always_ff @(posedge CLK or negedge NARST) begin
      if (!NARST) begin
         mosi_m <= 1'b0;
         mosi_s <= 1'b0;
      end else begin
         mosi_m <= MOSI;
         mosi_s <= mosi_m;
      end
   end

   assign hdr_nxt   = {hdr[AW-1:0], mosi_s};
   assign rw        = hdr[AW];
   assign addr      = hdr[AW-1:0];
   assign nxt_valid = int'(hdr_nxt[AW-1:0]) < NREG;
   assign wr_valid  = int'(addr) < NREG;

   // Unimplemented addresses fall through to zero; CTRL reads expose the error flag
   always_comb begin
      rd_val = '0;
      for (int k = 0; k < NREG; k++) begin
         if (hdr_nxt[AW-1:0] == AW'(k)) rd_val = regs[k];
      end
      if (hdr_nxt[AW-1:0] == AW'(ADDR_CTRL)) rd_val[ERRCLR_B] = SPI_ERR;
   end

   always_ff @(posedge CLK or negedge NARST) begin
      if (!NARST) begin
         state    <= IDLE;
         cnt      <= '0;
         hdr      <= '0;
         rx       <= '0;
         tx       <= '0;
         MISO     <= 1'b0;
         MISO_OE  <= 1'b0;
         FREQ_HOP <= 1'b0;
         SPI_ERR  <= 1'b0;
         sh_hi    <= FCW_RST[2*DW-1:DW];
         sh_lo    <= FCW_RST[DW-1:0];
         for (int k = 0; k < NREG; k++) regs[k] <= '0;
         regs[ADDR_FCW_HI] <= FCW_RST[2*DW-1:DW];
         regs[ADDR_FCW_LO] <= FCW_RST[DW-1:0];
      end else begin
         FREQ_HOP <= 1'b0;
         case (state)
            IDLE: begin
               if (csn_fall) begin
                  state <= HDR;
                  cnt   <= '0;
               end
            end
            HDR: begin
               if (csn_rise) begin
                  state   <= IDLE;
                  SPI_ERR <= 1'b1;
               end else if (sclk_rise) begin
                  hdr <= hdr_nxt;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(AW)) begin
                     state <= DATA;
                     tx    <= rd_val;
                     if (hdr_nxt[AW]) begin
                        MISO_OE <= 1'b1;
                        if (!nxt_valid) SPI_ERR <= 1'b1;
                     end
                  end
               end
            end
            DATA: begin
               if (csn_rise) begin
                  state   <= IDLE;
                  SPI_ERR <= 1'b1;
                  MISO    <= 1'b0;
                  MISO_OE <= 1'b0;
               end else begin
                  if (sclk_rise) begin
                     rx  <= {rx[DW-2:0], mosi_s};
                     cnt <= cnt + 1'b1;
                     if (cnt == CW'(L - 1)) state <= DONE;
                  end
                  if (sclk_fall && rw) begin
                     MISO <= tx[DW-1];
                     tx   <= {tx[DW-2:0], 1'b0};
                  end
               end
            end
            DONE: begin
               if (csn_rise) begin
                  state   <= IDLE;
                  MISO    <= 1'b0;
                  MISO_OE <= 1'b0;
                  if (!rw) begin
                     if (!wr_valid) begin
                        SPI_ERR <= 1'b1;
                     end else if (addr == AW'(ADDR_CTRL)) begin
                        regs[ADDR_CTRL] <= rx & CTRL_KEEP;
                        if (rx[COMMIT_B]) begin
                           regs[ADDR_FCW_HI] <= sh_hi;
                           regs[ADDR_FCW_LO] <= sh_lo;
                           FREQ_HOP          <= 1'b1;
                        end
                        if (rx[ERRCLR_B]) SPI_ERR <= 1'b0;
                     end else if (addr == AW'(ADDR_FCW_HI)) begin
                        sh_hi <= rx;
                     end else if (addr == AW'(ADDR_FCW_LO)) begin
                        sh_lo <= rx;
                     end else begin
                        for (int k = 3; k < NREG; k++) begin
                           if (addr == AW'(k)) regs[k] <= rx;
                        end
                     end
                  end
               end else if (sclk_rise) begin
                  SPI_ERR <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < NREG; k++) begin : g_q
      assign REG_Q[k*DW +: DW] = regs[k];
   end

   assign SYS_EN  = regs[ADDR_CTRL][SYS_EN_B];
   assign FCW_FOD = (WI+WF)'({regs[ADDR_FCW_HI], regs[ADDR_FCW_LO]});

endmodule

// File: tb/tb_fod_spi_regfile.sv
// tb/tb_fod_spi_regfile.sv - directed and randomized frames checked against a register-bank model
module tb_fod_spi_regfile;

   localparam int WI   = 7;
   localparam int WF   = 16;
   localparam int AW   = 6;
   localparam int DW   = 16;
   localparam int NREG = 16;
   localparam int L    = 1 + AW + DW;
   localparam int HALF = 6;

   logic clk = 1'b0;
   logic narst = 1'b0;
   logic sclk = 1'b0;
   logic csn = 1'b1;
   logic mosi = 1'b0;
   logic miso, miso_oe, sys_en, freq_hop, spi_err;
   logic [NREG*DW-1:0] reg_q;
   logic [WI+WF-1:0]   fcw_fod;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;

   logic [DW-1:0] m_reg [NREG];
   logic [DW-1:0] m_sh_hi, m_sh_lo;
   logic          m_err;

   int chg_cyc, fcw_cyc, hop_cyc, hop_cnt;
   logic oe_mid;
   logic [DW-1:0] rdata;

   always #5 clk = ~clk;

   fod_spi_regfile #(.WI(WI), .WF(WF), .AW(AW), .DW(DW), .NREG(NREG)) dut (
      .CLK(clk), .NARST(narst), .SCLK(sclk), .CSN(csn), .MOSI(mosi),
      .MISO(miso), .MISO_OE(miso_oe), .REG_Q(reg_q), .FCW_FOD(fcw_fod),
      .SYS_EN(sys_en), .FREQ_HOP(freq_hop), .SPI_ERR(spi_err)
   );

   task automatic check(input string tag, input logic [NREG*DW-1:0] obs, input logic [NREG*DW-1:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      logic [63:0] f;
      f = (64'd17 * (64'd1 << WF)) / 4;
      for (int k = 0; k < NREG; k++) m_reg[k] = '0;
      m_reg[1] = f[31:16];
      m_reg[2] = f[15:0];
      m_sh_hi  = f[31:16];
      m_sh_lo  = f[15:0];
      m_err    = 1'b0;
   endfunction

   function automatic void m_write(input int a, input logic [DW-1:0] d);
      if (a >= NREG) m_err = 1'b1;
      else if (a == 0) begin
         m_reg[0] = d & 16'h7FFD;
         if (d[1]) begin
            m_reg[1] = m_sh_hi;
            m_reg[2] = m_sh_lo;
         end
         if (d[15]) m_err = 1'b0;
      end
      else if (a == 1) m_sh_hi = d;
      else if (a == 2) m_sh_lo = d;
      else m_reg[a] = d;
   endfunction

   function automatic logic [DW-1:0] m_read(input int a);
      if (a >= NREG) begin
         m_err = 1'b1;
         return '0;
      end
      if (a == 0) return m_reg[0] | {m_err, 15'd0};
      return m_reg[a];
   endfunction

   function automatic logic [NREG*DW-1:0] m_regq();
      logic [NREG*DW-1:0] v;
      for (int k = 0; k < NREG; k++) v[k*DW +: DW] = m_reg[k];
      return v;
   endfunction

   function automatic logic [WI+WF-1:0] m_fcw();
      logic [2*DW-1:0] t;
      t = {m_reg[1], m_reg[2]};
      return t[WI+WF-1:0];
   endfunction

   task automatic spi_frame(input logic rw, input int a, input logic [DW-1:0] wd,
                            input int nbits, input bit end_cs, output logic [DW-1:0] rd);
      logic [L-1:0] fr;
      fr = {rw, AW'(a), wd};
      rd = '0;
      csn = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         mosi = fr[L-1-i];
         repeat (HALF) @(negedge clk);
         if (i >= 1 + AW) rd = {rd[DW-2:0], miso};
         if (i == L - 1) oe_mid = miso_oe;
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
      if (end_cs) begin
         repeat (HALF) @(negedge clk);
         csn = 1'b1;
      end
   endtask

   task automatic observe(input int ncyc);
      logic [NREG*DW-1:0] q0;
      logic [WI+WF-1:0]   f0;
      q0 = reg_q;
      f0 = fcw_fod;
      chg_cyc = 0; fcw_cyc = 0; hop_cyc = 0; hop_cnt = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (chg_cyc == 0 && reg_q !== q0) chg_cyc = c;
         if (fcw_cyc == 0 && fcw_fod !== f0) fcw_cyc = c;
         if (freq_hop === 1'b1) begin
            hop_cnt++;
            if (hop_cyc == 0) hop_cyc = c;
         end
      end
   endtask

   task automatic xfer(input logic rw, input int a, input logic [DW-1:0] wd);
      logic [DW-1:0] exp_rd;
      string t;
      t = $sformatf("%s a=%0d d=%h", rw ? "rd" : "wr", a, wd);
      oe_mid = 1'bx;
      spi_frame(rw, a, wd, L, 1'b1, rdata);
      observe(10);
      if (rw) begin
         exp_rd = m_read(a);
         check({t, " miso_data"}, rdata, exp_rd);
      end else begin
         m_write(a, wd);
      end
      check({t, " miso_oe_in_frame"}, oe_mid, rw);
      check({t, " reg_q"}, reg_q, m_regq());
      check({t, " fcw_fod"}, fcw_fod, m_fcw());
      check({t, " sys_en"}, sys_en, m_reg[0][0]);
      check({t, " spi_err"}, spi_err, m_err);
      check({t, " miso_oe_idle"}, miso_oe, 1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic rw;
      int a;
      logic [DW-1:0] d;

      m_reset();
      repeat (4) @(negedge clk);
      narst = 1'b1;
      repeat (4) @(negedge clk);

      check("reset fcw_fod", fcw_fod, 23'h44000);
      check("reset reg_q", reg_q, m_regq());
      check("reset sys_en", sys_en, 1'b0);
      check("reset miso_oe", miso_oe, 1'b0);
      check("reset miso", miso, 1'b0);
      check("reset spi_err", spi_err, 1'b0);
      check("reset freq_hop", freq_hop, 1'b0);

      xfer(1'b0, 5, 16'hA5C3);
      check("wr5 latency within 4", (chg_cyc >= 1 && chg_cyc <= 4), 1'b1);
      xfer(1'b1, 5, 16'h0000);
      check("rd5 value", rdata, 16'hA5C3);

      xfer(1'b0, 1, 16'h0008);
      xfer(1'b0, 2, 16'h8000);
      check("shadow only fcw", fcw_fod, 23'h44000);
      xfer(1'b0, 0, 16'h0003);
      check("commit fcw", fcw_fod, 23'h88000);
      check("commit hop count", hop_cnt, 1);
      check("commit hop aligned", hop_cyc, fcw_cyc);
      check("commit sys_en", sys_en, 1'b1);
      check("ctrl bit1 not stored", reg_q[1], 1'b0);
      xfer(1'b1, 0, 16'h0000);
      check("rd ctrl", rdata, 16'h0001);

      oe_mid = 1'b0;
      spi_frame(1'b0, 4, 16'hBEEF, 10, 1'b1, rdata);
      observe(10);
      m_err = 1'b1;
      check("abort reg_q", reg_q, m_regq());
      check("abort spi_err", spi_err, 1'b1);
      xfer(1'b1, 0, 16'h0000);
      check("rd ctrl err bit", rdata, 16'h8001);
      xfer(1'b0, 0, 16'h8000);
      check("errclr spi_err", spi_err, 1'b0);

      xfer(1'b0, 40, 16'h1357);
      check("wr40 spi_err", spi_err, 1'b1);
      xfer(1'b0, 0, 16'h8000);
      xfer(1'b1, 40, 16'h0000);
      check("rd40 data", rdata, 16'h0000);
      check("rd40 spi_err", spi_err, 1'b1);

      xfer(1'b0, 3, 16'h1234);
      spi_frame(1'b0, 3, 16'hFFFF, 12, 1'b0, rdata);
      narst = 1'b0;
      sclk = 1'b0;
      csn = 1'b1;
      repeat (2) @(negedge clk);
      m_reset();
      check("midframe reset reg3", reg_q[3*DW +: DW], 16'h0000);
      check("midframe reset reg_q", reg_q, m_regq());
      check("midframe reset spi_err", spi_err, 1'b0);
      narst = 1'b1;
      repeat (4) @(negedge clk);
      check("after reset miso_oe", miso_oe, 1'b0);
      xfer(1'b0, 3, 16'h5A5A);
      xfer(1'b1, 3, 16'h0000);

      for (int n = 0; n < 30; n++) begin
         rw = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, NREG - 1));
         d  = 16'($urandom);
         xfer(rw, a, d);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
